// File: rtl/pwm_dec.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_dec
//  Description : Receive-side PWM decoder. Synchronizes the asynchronous
//                PWM_1V8 line, measures the high time and the period of each
//                complete PWM cycle in clock cycles and reports them with a
//                one-cycle valid pulse. A phase that stays at one level for
//                longer than TIMEOUT clocks is reported as a stuck line.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_dec #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 16384
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             PWM_1V8,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             timeout,
    output logic             stuck,
    output logic [1:0]       state
);

    // ------------------------------------------------------------------------
    // State encoding. Code 3 is unused and recovers to IDLE.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Counter limits at counter width. TIMEOUT < 2^(CNT_W-1) keeps the sum
    // of a maximal high and a maximal low phase inside CNT_W bits.
    localparam logic [CNT_W-1:0] TMO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // ------------------------------------------------------------------------
    // Input synchronizer and edge detection
    // ------------------------------------------------------------------------
    logic s1;
    logic s2;
    logic sp;
    logic rise;
    logic fall;

    // Two-flop synchronizer for the asynchronous line plus a delayed copy
    // of the synchronized level for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            sp <= 1'b0;
        end else begin
            s1 <= PWM_1V8;
            s2 <= s1;
            sp <= s2;
        end
    end

    assign rise = s2 & ~sp;
    assign fall = ~s2 & sp;

    // ------------------------------------------------------------------------
    // FSM and measurement datapath
    // ------------------------------------------------------------------------
    state_t           cur_state;
    state_t           nxt_state;

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] lcnt;
    logic [CNT_W-1:0] hcnt_nxt;
    logic [CNT_W-1:0] lcnt_nxt;
    logic [CNT_W-1:0] high_nxt;
    logic [CNT_W-1:0] period_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;
    logic             stuck_nxt;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state, counter and result logic. An edge arriving in the same
    // cycle that a counter reaches the limit takes priority over the
    // timeout, so a phase of exactly TIMEOUT clocks is still measured.
    always_comb begin
        nxt_state   = cur_state;
        hcnt_nxt    = hcnt;
        lcnt_nxt    = lcnt;
        high_nxt    = high_cnt;
        period_nxt  = period_cnt;
        valid_nxt   = 1'b0;
        timeout_nxt = timeout;
        stuck_nxt   = stuck;

        if (!en) begin
            // Disabled: abandon any measurement, keep the last results.
            nxt_state = IDLE;
            hcnt_nxt  = CNT_ZERO;
            lcnt_nxt  = CNT_ZERO;
        end else begin
            case (cur_state)
                IDLE: begin
                    hcnt_nxt = CNT_ZERO;
                    lcnt_nxt = CNT_ZERO;
                    if (rise) begin
                        // The rise cycle is the first high clock.
                        nxt_state = HIGH;
                        hcnt_nxt  = CNT_ONE;
                    end
                end

                HIGH: begin
                    if (fall) begin
                        // The fall cycle is the first low clock.
                        nxt_state = LOW;
                        lcnt_nxt  = CNT_ONE;
                    end else if (hcnt == TMO_VAL) begin
                        nxt_state   = IDLE;
                        hcnt_nxt    = CNT_ZERO;
                        lcnt_nxt    = CNT_ZERO;
                        timeout_nxt = 1'b1;
                        stuck_nxt   = s2;
                    end else if (s2) begin
                        hcnt_nxt = hcnt + CNT_ONE;
                    end
                end

                LOW: begin
                    if (rise) begin
                        // A full cycle has completed: publish it and start
                        // measuring the next high phase right away.
                        high_nxt    = hcnt;
                        period_nxt  = hcnt + lcnt;
                        valid_nxt   = 1'b1;
                        timeout_nxt = 1'b0;
                        nxt_state   = HIGH;
                        hcnt_nxt    = CNT_ONE;
                        lcnt_nxt    = CNT_ZERO;
                    end else if (lcnt == TMO_VAL) begin
                        nxt_state   = IDLE;
                        hcnt_nxt    = CNT_ZERO;
                        lcnt_nxt    = CNT_ZERO;
                        timeout_nxt = 1'b1;
                        stuck_nxt   = s2;
                    end else if (!s2) begin
                        lcnt_nxt = lcnt + CNT_ONE;
                    end
                end

                default: begin
                    // Illegal encoding: recover cleanly.
                    nxt_state = IDLE;
                    hcnt_nxt  = CNT_ZERO;
                    lcnt_nxt  = CNT_ZERO;
                end
            endcase
        end
    end

    // Counter and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt       <= CNT_ZERO;
            lcnt       <= CNT_ZERO;
            high_cnt   <= CNT_ZERO;
            period_cnt <= CNT_ZERO;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            hcnt       <= hcnt_nxt;
            lcnt       <= lcnt_nxt;
            high_cnt   <= high_nxt;
            period_cnt <= period_nxt;
            valid      <= valid_nxt;
            timeout    <= timeout_nxt;
            stuck      <= stuck_nxt;
        end
    end

    assign state = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_pwm_dec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_dec
//  Description : Directed self-checking bench for pwm_dec. Two instances share
//                one stimulus: one with TIMEOUT=64 for the stuck-line cases,
//                one with the default TIMEOUT for long phases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_dec;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        pwm;

    logic [15:0] a_high, a_period, b_high, b_period;
    logic        a_valid, a_timeout, a_stuck;
    logic        b_valid, b_timeout, b_stuck;
    logic [1:0]  a_state, b_state;

    pwm_dec #(.CNT_W(16), .TIMEOUT(64)) dut_t64 (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .PWM_1V8    (pwm),
        .high_cnt   (a_high),
        .period_cnt (a_period),
        .valid      (a_valid),
        .timeout    (a_timeout),
        .stuck      (a_stuck),
        .state      (a_state)
    );

    pwm_dec #(.CNT_W(16)) dut_big (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .PWM_1V8    (pwm),
        .high_cnt   (b_high),
        .period_cnt (b_period),
        .valid      (b_valid),
        .timeout    (b_timeout),
        .stuck      (b_stuck),
        .state      (b_state)
    );

    always #5 clk = ~clk;

    // Rising-edge counter used to time valid pulses.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Valid monitors: count pulses and capture results at each pulse.
    int          va_n = 0, va_cyc = 0, va_gap = 0;
    int          vb_n = 0, vb_cyc = 0;
    logic [15:0] va_h = '0, va_p = '0, vb_h = '0, vb_p = '0;

    always @(negedge clk) begin
        if (a_valid) begin
            va_n   <= va_n + 1;
            va_gap <= cyc - va_cyc;
            va_cyc <= cyc;
            va_h   <= a_high;
            va_p   <= a_period;
        end
    end

    always @(negedge clk) begin
        if (b_valid) begin
            vb_n   <= vb_n + 1;
            vb_cyc <= cyc;
            vb_h   <= b_high;
            vb_p   <= b_period;
        end
    end

    int total = 0;
    int bad   = 0;
    int rise_cyc = 0;
    int b_base = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive the line at a level for n clocks; starts and ends 1 time unit
    // after a rising edge.
    task automatic phase(input logic lvl, input int n);
        if (lvl && !pwm) rise_cyc = cyc;
        pwm = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        pwm   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state",   a_state,   0);
        check("rst_high",    a_high,    0);
        check("rst_period",  a_period,  0);
        check("rst_valid",   a_valid,   0);
        check("rst_timeout", a_timeout, 0);
        check("rst_stuck",   a_stuck,   0);
        reset = 1'b0;
        en    = 1'b1;

        // Steady 40/60.
        phase(1'b1, 40);
        phase(1'b0, 60);
        check("first_rise_no_valid", va_n, 0);
        phase(1'b1, 40);
        check("second_rise_valid", va_n, 1);
        check("valid_latency", va_cyc - rise_cyc, 3);
        check("steady_high", va_h, 40);
        check("steady_period", va_p, 100);
        phase(1'b0, 60);
        phase(1'b1, 40);
        check("steady_count", va_n, 2);
        check("steady_gap", va_gap, 100);
        check("big_steady_count", vb_n, 2);

        // Duty change to 75/25; TIMEOUT=64 instance sees a stuck high.
        phase(1'b0, 60);
        phase(1'b1, 66);
        check("duty_old_count", vb_n, 3);
        check("duty_old_high", vb_h, 40);
        check("duty_old_period", vb_p, 100);
        check("t64_good_count", va_n, 3);
        check("stuck_hi_not_yet", a_timeout, 0);
        phase(1'b1, 1);
        check("stuck_hi_timeout", a_timeout, 1);
        check("stuck_hi_level", a_stuck, 1);
        check("stuck_hi_state", a_state, 0);
        check("stuck_hi_hold_h", a_high, 40);
        check("stuck_hi_hold_p", a_period, 100);
        phase(1'b1, 8);
        phase(1'b0, 25);
        phase(1'b1, 30);
        check("duty_new_count", vb_n, 4);
        check("duty_new_high", vb_h, 75);
        check("duty_new_period", vb_p, 100);

        // Restart with 10/10 after the stuck high.
        phase(1'b0, 10);
        phase(1'b1, 10);
        phase(1'b0, 10);
        phase(1'b1, 10);
        check("rearm_count", va_n, 5);
        check("rearm_high", va_h, 10);
        check("rearm_period", va_p, 20);
        check("rearm_timeout_clr", a_timeout, 0);

        // Stuck low on the TIMEOUT=64 instance.
        phase(1'b0, 66);
        check("stuck_lo_not_yet", a_timeout, 0);
        phase(1'b0, 1);
        check("stuck_lo_timeout", a_timeout, 1);
        check("stuck_lo_level", a_stuck, 0);
        check("stuck_lo_state", a_state, 0);
        check("stuck_lo_hold_h", a_high, 10);
        check("stuck_lo_hold_p", a_period, 20);
        phase(1'b0, 13);

        // Asynchronous reset during a high phase.
        phase(1'b1, 20);
        check("pre_rst_big_high", b_high, 10);
        b_base = vb_n;
        reset = 1'b1;
        pwm   = 1'b0;
        #1;
        check("arst_high", b_high, 0);
        check("arst_period", b_period, 0);
        check("arst_state", b_state, 0);
        check("arst_timeout", a_timeout, 0);
        check("arst_stuck", a_stuck, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        phase(1'b0, 10);
        phase(1'b1, 10);
        phase(1'b0, 10);
        check("post_rst_no_valid", vb_n, b_base);
        phase(1'b1, 10);
        check("post_rst_count", vb_n, b_base + 1);
        check("post_rst_high", vb_h, 10);
        check("post_rst_period", vb_p, 20);

        // Enable dropped mid-period for 5 clocks.
        phase(1'b0, 10);
        phase(1'b1, 8);
        en = 1'b0;
        phase(1'b1, 5);
        check("en_low_idle", b_state, 0);
        en = 1'b1;
        phase(1'b1, 7);
        phase(1'b0, 30);
        b_base = vb_n;
        phase(1'b1, 20);
        check("en_no_valid", vb_n, b_base);
        phase(1'b0, 30);
        phase(1'b1, 5);
        check("en_next_count", vb_n, b_base + 1);
        check("en_next_high", vb_h, 20);
        check("en_next_period", vb_p, 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_dec.md
# pwm_dec

Receive-side decoder for the temperature sensor's PWM output. It samples the asynchronous `PWM_1V8` line, measures the high time and period of each PWM cycle in clock cycles, and emits a one-cycle `valid` pulse with the result. It sits on the consumer side of the sensor digital and recovers the temperature-dependent duty cycle for readout or register capture. It also flags a stuck line (0 % or 100 % duty) through a timeout.

## Interface
Parameters:
- `CNT_W`, 16: width of `high_cnt`, `period_cnt` and the internal counters.
- `TIMEOUT`, 16384: maximum high or low phase length in clocks before a stuck line is declared. Must satisfy 2 ≤ TIMEOUT < 2^(CNT_W-1).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  synchronous enable; low forces IDLE on the next edge.
- `PWM_1V8`  in  1  PWM line, asynchronous to `clk`.
- `high_cnt`  out  CNT_W  high time of the last complete PWM cycle, in clocks.
- `period_cnt`  out  CNT_W  period of the last complete PWM cycle, in clocks.
- `valid`  out  1  one-cycle pulse when `high_cnt`/`period_cnt` update.
- `timeout`  out  1  sticky stuck-line flag.
- `stuck`  out  1  line level at timeout: 1 = 100 % duty, 0 = 0 % duty.
- `state`  out  2  current FSM state.

## Operation
- Input path: 2-flop synchronizer (`s1`, `s2`) plus a previous-value register `sp`.
  - `rise` = `s2 & ~sp`.
  - `fall` = `~s2 & sp`.
- Registered FSM. States: IDLE=0, HIGH=1, LOW=2. Code 3 is illegal and goes to IDLE on the next edge.
- IDLE:
  - Counters are held at 0.
  - On `rise` with `en`=1: go to HIGH, `hcnt`=1.
- HIGH:
  - `s2`=1: `hcnt`++.
  - `fall`: go to LOW, `lcnt`=1.
- LOW:
  - `s2`=0: `lcnt`++.
  - `rise`: load `high_cnt`=`hcnt` and `period_cnt`=`hcnt`+`lcnt`, pulse `valid`=1, clear `timeout`, go to HIGH with `hcnt`=1.
- Result for a line with H clocks high and L clocks low: `high_cnt`=H, `period_cnt`=H+L. The TIMEOUT bound guarantees the sum fits in CNT_W bits, so no wrap is possible.
- Timeout:
  - Condition: in HIGH with `hcnt`==TIMEOUT and no `fall`, or in LOW with `lcnt`==TIMEOUT and no `rise`.
  - Action: set `timeout`=1 and `stuck`=`s2`, go to IDLE.
  - `high_cnt`/`period_cnt` hold their previous values.
- Re-arm after timeout: IDLE waits for a fresh `rise`. `timeout` remains set until the next `valid`.
- Simultaneous events: a `rise`/`fall` in the same cycle the count reaches TIMEOUT is treated as an edge, not a timeout.
- `en` low:
  - Next edge goes to IDLE; counters are cleared.
  - `high_cnt`, `period_cnt`, `timeout` and `stuck` hold their values.
  - No `valid` is produced.
- The first cycle after leaving IDLE is never reported. The first `valid` comes at the second rising edge seen.

## Timing
- Reset values:
  - `state`=IDLE.
  - `high_cnt`=0, `period_cnt`=0.
  - `valid`=0, `timeout`=0, `stuck`=0.
  - `s1`=`s2`=`sp`=0, internal counters 0.
- Reset asserted mid-measurement aborts it immediately (asynchronously). No `valid` is produced for the interrupted cycle.
- Latency: a raw `PWM_1V8` rising edge sampled at clk edge k produces `valid`=1 in the cycle after edge k+2.
- `valid` is exactly one cycle wide, at most one per PWM period.
- `high_cnt`/`period_cnt` change only in the cycle `valid` is high.
- Minimum phase: high and low phases must each last ≥ 2 clocks to be measured. Shorter pulses may be filtered by the synchronizer.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Test plan
- Steady PWM: H=40, L=60 clocks, repeated, `en`=1.
  - First `valid` at the 2nd rise; then `high_cnt`=40, `period_cnt`=100, and `valid` pulses every 100 clocks.
- Duty change: H=40/L=60 switched to H=75/L=25.
  - Next `valid` reports 40/100; the following one reports 75/100.
- Stuck high: after one good cycle, hold `PWM_1V8`=1, with TIMEOUT=64.
  - `timeout`=1 and `stuck`=1 after the high phase reaches 64 clocks; `state`=IDLE; `high_cnt`/`period_cnt` keep their last values.
  - Restart a 10/10 PWM: `valid` with 10/20 and `timeout` clears.
- Stuck low: hold 0 with TIMEOUT=64.
  - `timeout`=1, `stuck`=0 after `lcnt` reaches 64.
- Reset mid-measurement: assert `reset` during a HIGH phase.
  - All outputs read 0 immediately.
  - After release, no `valid` until two further rises.
- Enable gating: drop `en` mid-period for 5 clocks, then raise it.
  - No `valid` for the interrupted cycle.
  - Next full cycle reports correct H and H+L.
